tipi_link_seq: RTL and testbench

//  RPi-side sequencer for the TIPI 4-register serial link (RD, RC, TD, TC).

---
 rtl/tipi_link_seq_pkg.sv | 34 +++
 rtl/tipi_link_seq_if.sv | 32 +++
 rtl/tipi_link_seq_timer.sv | 30 +++
 rtl/tipi_link_seq.sv | 150 +++++++++++++++
 tb/tb_tipi_link_seq.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tipi_link_seq_pkg.sv
// TIPI link sequencer shared definitions.
// FSM state encodings, register-select values and link-pin decode helpers.
package tipi_link_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_LOAD   = 3'd2,
        S_BIT_LO = 3'd3,
        S_BIT_HI = 3'd4,
        S_LATCH  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic RT_RPI  = 1'b0;
    localparam logic RT_TI   = 1'b1;
    localparam logic DC_DATA = 1'b0;
    localparam logic DC_CTRL = 1'b1;

    localparam logic [2:0] LAST_BIT = 3'd7;

    function automatic logic link_clk(input state_t s);
        return (s == S_LOAD) || (s == S_BIT_HI);
    endfunction

    function automatic logic link_le(input state_t s);
        return (s == S_LOAD) || (s == S_LATCH);
    endfunction

    function automatic logic is_bit(input state_t s);
        return (s == S_BIT_LO) || (s == S_BIT_HI);
    endfunction

endpackage

// File: rtl/tipi_link_seq_if.sv
// TIPI link sequencer bus: host command/response handshake plus link pins.
// slave = sequencer side, master = host driver / pin owner side.
interface tipi_link_seq_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic       cmd_ctrl;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       r_clk;
    logic       r_le;
    logic       r_rt;
    logic       r_dc;
    logic       r_dout;
    logic       r_din;

    modport slave (
        input  cmd_valid, cmd_write, cmd_ctrl, cmd_wdata, r_din,
        output cmd_ready, rsp_valid, rsp_data, busy,
        output r_clk, r_le, r_rt, r_dc, r_dout
    );

    modport master (
        output cmd_valid, cmd_write, cmd_ctrl, cmd_wdata, r_din,
        input  cmd_ready, rsp_valid, rsp_data, busy,
        input  r_clk, r_le, r_rt, r_dc, r_dout
    );

endinterface

// File: rtl/tipi_link_seq_timer.sv
// Phase timer: down-counter reloaded on every phase entry.
// o_phase_end marks the last cycle of the current link phase.
module tipi_phase_timer #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_load,
    output logic o_phase_end
);

    localparam int W = $clog2(HALF_PERIOD + 1);
    localparam logic [W-1:0] RELOAD = W'(HALF_PERIOD - 1);

    logic [W-1:0] r_cnt;

    // Reload on phase entry, otherwise count down and park at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_phase_end = (r_cnt == '0);

endmodule

// File: rtl/tipi_link_seq.sv
// TIPI 4-register link sequencer (RPi side).
// Turns one byte command into r_rt/r_dc/r_le/r_clk/r_dout waveforms.
module tipi_link_seq
    import tipi_link_seq_pkg::*;
#(
    parameter int HALF_PERIOD = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    tipi_link_seq_if.slave bus
);

    state_t     r_state;
    state_t     w_nstate;
    logic       w_pe;
    logic       w_load;
    logic       w_acc;
    logic       r_wr;
    logic       r_ctrl;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic [2:0] r_bit;
    logic [2:0] w_nbit;
    logic       r_lclk;
    logic       r_lle;
    logic       r_lrt;
    logic       r_ldc;
    logic       r_ldout;
    logic       r_rspv;
    logic       r_busy;
    logic [7:0] r_rsp;

    assign w_acc  = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_load = (w_nstate != r_state);

    tipi_phase_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_load),
        .o_phase_end (w_pe)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    // Next-state: each phase advances when the timer reports its last cycle
    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            S_IDLE:   if (bus.cmd_valid) w_nstate = S_SETUP;
            S_SETUP:  if (w_pe) w_nstate = r_wr ? S_BIT_LO : S_LOAD;
            S_LOAD:   if (w_pe) w_nstate = S_BIT_LO;
            S_BIT_LO: if (w_pe) w_nstate = S_BIT_HI;
            S_BIT_HI: begin
                if (w_pe) begin
                    if (r_bit != LAST_BIT) begin
                        w_nstate = S_BIT_LO;
                    end else begin
                        w_nstate = r_wr ? S_LATCH : S_DONE;
                    end
                end
            end
            S_LATCH:  if (w_pe) w_nstate = S_DONE;
            S_DONE:   w_nstate = S_IDLE;
            default:  w_nstate = S_IDLE;
        endcase
    end

    // Bit index: cleared on accept, stepped when a BIT_HI phase ends
    always_comb begin
        w_nbit = r_bit;
        if (w_acc) begin
            w_nbit = 3'd0;
        end else if ((r_state == S_BIT_HI) && w_pe && (r_bit != LAST_BIT)) begin
            w_nbit = r_bit + 3'd1;
        end
    end

    // Command capture at accept and bit counter update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr   <= 1'b0;
            r_ctrl <= 1'b0;
            r_tx   <= 8'h00;
            r_bit  <= 3'd0;
        end else begin
            r_bit <= w_nbit;
            if (w_acc) begin
                r_wr   <= bus.cmd_write;
                r_ctrl <= bus.cmd_ctrl;
                r_tx   <= bus.cmd_wdata;
            end
        end
    end

    // Receive shifter: sample r_din in the last cycle of each low phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx <= 8'h00;
        end else if ((r_state == S_BIT_LO) && w_pe) begin
            r_rx <= {bus.r_din, r_rx[7:1]};
        end
    end

    // Link pins and response, registered from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lclk  <= 1'b0;
            r_lle   <= 1'b0;
            r_lrt   <= 1'b0;
            r_ldc   <= 1'b0;
            r_ldout <= 1'b0;
            r_rspv  <= 1'b0;
            r_busy  <= 1'b0;
            r_rsp   <= 8'h00;
        end else begin
            r_lclk  <= link_clk(w_nstate);
            r_lle   <= link_le(w_nstate);
            r_ldout <= is_bit(w_nstate) && r_wr && r_tx[w_nbit];
            r_rspv  <= (w_nstate == S_DONE);
            r_busy  <= (w_nstate != S_IDLE);
            if (w_acc) begin
                r_lrt <= bus.cmd_write ? RT_RPI : RT_TI;
                r_ldc <= bus.cmd_ctrl ? DC_CTRL : DC_DATA;
            end
            if ((w_nstate == S_DONE) && !r_wr) begin
                r_rsp <= r_rx;
            end
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = r_rspv;
    assign bus.rsp_data  = r_rsp;
    assign bus.busy      = r_busy;
    assign bus.r_clk     = r_lclk;
    assign bus.r_le      = r_lle;
    assign bus.r_rt      = r_lrt;
    assign bus.r_dc      = r_ldc;
    assign bus.r_dout    = r_ldout;

endmodule

// File: tb/tb_tipi_link_seq.sv
// Testbench for tipi_link_seq: HALF_PERIOD=4 and HALF_PERIOD=1 instances.
// Phase-table model plus a CPLD-side register model on the link pins.
module tb_tipi_link_seq;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    tipi_link_seq_if ia();
    tipi_link_seq_if ib();

    tipi_link_seq #(.HALF_PERIOD(4)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ia.slave)
    );

    tipi_link_seq #(.HALF_PERIOD(1)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ib.slave)
    );

    // host-side stimulus
    logic       cv [2];
    logic       cw [2];
    logic       cc [2];
    logic [7:0] cwd [2];

    assign ia.cmd_valid = cv[0];
    assign ia.cmd_write = cw[0];
    assign ia.cmd_ctrl  = cc[0];
    assign ia.cmd_wdata = cwd[0];
    assign ib.cmd_valid = cv[1];
    assign ib.cmd_write = cw[1];
    assign ib.cmd_ctrl  = cc[1];
    assign ib.cmd_wdata = cwd[1];

    // observed outputs {ready,busy,rv,clk,le,rt,dc,dout,rsp_data}
    logic [15:0] o_vec [2];
    assign o_vec[0] = {ia.cmd_ready, ia.busy, ia.rsp_valid, ia.r_clk,
                       ia.r_le, ia.r_rt, ia.r_dc, ia.r_dout, ia.rsp_data};
    assign o_vec[1] = {ib.cmd_ready, ib.busy, ib.rsp_valid, ib.r_clk,
                       ib.r_le, ib.r_rt, ib.r_dc, ib.r_dout, ib.rsp_data};

    // CPLD register model on the far side of the link
    logic [7:0] td_val = 8'h00;
    logic [7:0] tc_val = 8'h00;
    logic [7:0] sr_tx [2] = '{8'h00, 8'h00};
    logic [7:0] sr_rx [2] = '{8'h00, 8'h00};
    logic [7:0] cp_rd [2] = '{8'h00, 8'h00};
    logic [7:0] cp_rc [2] = '{8'h00, 8'h00};
    logic       pclk [2] = '{1'b0, 1'b0};
    logic       ple [2] = '{1'b0, 1'b0};
    int         nrise [2] = '{0, 0};

    assign ia.r_din = sr_tx[0][0];
    assign ib.r_din = sr_tx[1][0];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (o_vec[k][12] && !pclk[k]) begin
                nrise[k] <= nrise[k] + 1;
                if (o_vec[k][11]) begin
                    sr_tx[k] <= o_vec[k][9] ? tc_val : td_val;
                end else begin
                    sr_tx[k] <= sr_tx[k] >> 1;
                    sr_rx[k] <= {o_vec[k][8], sr_rx[k][7:1]};
                end
            end
            if (o_vec[k][11] && !ple[k] && !o_vec[k][12]) begin
                if (o_vec[k][9]) cp_rc[k] <= sr_rx[k];
                else cp_rd[k] <= sr_rx[k];
            end
            pclk[k] <= o_vec[k][12];
            ple[k]  <= o_vec[k][11];
        end
    end

    // behavioural model: transfer = 18 phases of HP cycles, then DONE
    int         hpv [2] = '{4, 1};
    bit         m_busy [2];
    int         m_t [2];
    bit         m_wr [2];
    bit         m_ctrl [2];
    bit         m_rt [2];
    bit         m_dc [2];
    logic [7:0] m_wd [2];
    logic [7:0] m_rd [2];

    always @(posedge clk or negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_busy[k] = 1'b0;
                m_t[k]    = 0;
                m_rt[k]   = 1'b0;
                m_dc[k]   = 1'b0;
                m_rd[k]   = 8'h00;
            end else if (m_busy[k]) begin
                m_t[k] = m_t[k] + 1;
                if (m_t[k] == 18 * hpv[k] && !m_wr[k])
                    m_rd[k] = m_ctrl[k] ? tc_val : td_val;
                if (m_t[k] > 18 * hpv[k])
                    m_busy[k] = 1'b0;
            end else if (cv[k]) begin
                m_busy[k] = 1'b1;
                m_t[k]    = 0;
                m_wr[k]   = cw[k];
                m_ctrl[k] = cc[k];
                m_wd[k]   = cwd[k];
                m_rt[k]   = !cw[k];
                m_dc[k]   = cc[k];
            end
        end
    end

    // {clk, le, dout} for offset t into a transfer
    function automatic logic [2:0] exp_pins(int hp, bit wr,
                                            logic [7:0] wd, int t);
        int p;
        int i;
        int hi;
        p = t / hp;
        if (t >= 18 * hp || p == 0) return 3'b000;
        if (wr) begin
            if (p == 17) return 3'b010;
            i  = (p - 1) / 2;
            hi = (p - 1) % 2;
            return {hi[0], 1'b0, wd[i]};
        end
        if (p == 1) return 3'b110;
        hi = (p - 2) % 2;
        return {hi[0], 2'b00};
    endfunction

    function automatic logic [15:0] exp_vec(int k);
        logic [2:0] pins;
        logic rdy;
        logic bsy;
        logic rv;
        pins = 3'b000;
        rdy  = 1'b1;
        bsy  = 1'b0;
        rv   = 1'b0;
        if (m_busy[k]) begin
            rdy  = 1'b0;
            bsy  = 1'b1;
            rv   = (m_t[k] == 18 * hpv[k]);
            pins = exp_pins(hpv[k], m_wr[k], m_wd[k], m_t[k]);
        end
        return {rdy, bsy, rv, pins[2], pins[1], m_rt[k], m_dc[k],
                pins[0], m_rd[k]};
    endfunction

    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b0;
    int  cyc = 0;
    int  hs_cyc [2] = '{0, 0};
    int  ndone [2] = '{0, 0};
    int  lecnt [2] = '{0, 0};
    int  viol = 0;
    logic [1:0] prt [2] = '{2'b00, 2'b00};
    logic       pck [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (cv[k] && o_vec[k][15]) hs_cyc[k] = cyc;
        cyc = cyc + 1;
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [15:0] e;
                e = exp_vec(k);
                checks = checks + 1;
                if (o_vec[k] !== e) begin
                    errors = errors + 1;
                    $display("FAIL cycle%0d dut%0d got %h exp %h",
                             cyc, k, o_vec[k], e);
                end
                if (o_vec[k][13]) ndone[k] = ndone[k] + 1;
                if (o_vec[k][11]) lecnt[k] = lecnt[k] + 1;
                if (o_vec[k][10:9] != prt[k] && (o_vec[k][12] || pck[k]))
                    viol = viol + 1;
                prt[k] = o_vec[k][10:9];
                pck[k] = o_vec[k][12];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic issue(input int k, input bit wr, input bit ctrl,
                         input logic [7:0] wd);
        cv[k]  = 1'b1;
        cw[k]  = wr;
        cc[k]  = ctrl;
        cwd[k] = wd;
    endtask

    task automatic wait_acc(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (o_vec[k][15] && cv[k]) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int k, output bit ok, output int dcyc);
        ok   = 1'b0;
        dcyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (o_vec[k][13]) begin
                ok   = 1'b1;
                dcyc = cyc;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int d1;
        int d2;
        int nr;
        int nl;
        int nd;
        for (int k = 0; k < 2; k++) begin
            cv[k]  = 1'b0;
            cw[k]  = 1'b0;
            cc[k]  = 1'b0;
            cwd[k] = 8'h00;
        end
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a", o_vec[0], 16'h8000);
        check("rst_b", o_vec[1], 16'h8000);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        @(posedge clk);
        #1;

        // write RD A5
        nr = nrise[0];
        nl = lecnt[0];
        issue(0, 1'b1, 1'b0, 8'hA5);
        wait_acc(0, ok);
        cv[0] = 1'b0;
        check("wr_acc", ok, 1);
        wait_rsp(0, ok, d1);
        check("wr_rsp", ok, 1);
        check("wr_lat", d1 - (hs_cyc[0] + 1), 72);
        repeat (2) @(posedge clk);
        #1;
        check("wr_rd", cp_rd[0], 8'hA5);
        check("wr_rises", nrise[0] - nr, 8);
        check("wr_le", lecnt[0] - nl, 4);

        // read TC 3C
        tc_val = 8'h3C;
        issue(0, 1'b0, 1'b1, 8'h00);
        wait_acc(0, ok);
        cv[0] = 1'b0;
        check("rd_acc", ok, 1);
        wait_rsp(0, ok, d1);
        check("rd_rsp", ok, 1);
        check("rd_lat", d1 - (hs_cyc[0] + 1), 72);
        check("rd_data", o_vec[0][7:0], 8'h3C);
        check("rd_rtdc", o_vec[0][10:9], 2'b11);

        // back-to-back: write RC FF then read TD 81, valid held
        td_val = 8'h81;
        issue(0, 1'b1, 1'b1, 8'hFF);
        wait_acc(0, ok);
        check("b2b_acc1", ok, 1);
        issue(0, 1'b0, 1'b0, 8'h00);
        wait_rsp(0, ok, d1);
        check("b2b_rsp1", ok, 1);
        wait_acc(0, ok);
        cv[0] = 1'b0;
        check("b2b_acc2", ok, 1);
        check("b2b_gap", hs_cyc[0] - d1, 1);
        wait_rsp(0, ok, d2);
        check("b2b_rsp2", ok, 1);
        check("b2b_data", o_vec[0][7:0], 8'h81);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_rc", cp_rc[0], 8'hFF);
        check("rtdc_stable", viol, 0);

        // abort during bit 4 of a write
        issue(0, 1'b1, 1'b0, 8'h33);
        wait_acc(0, ok);
        cv[0] = 1'b0;
        check("ab_acc", ok, 1);
        repeat (38) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("ab_rst", o_vec[0], 16'h8000);
        nd = ndone[0];
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("ab_norsp", ndone[0] - nd, 0);
        check("ab_rd", cp_rd[0], 8'hA5);

        // fresh write 5A after abort
        issue(0, 1'b1, 1'b0, 8'h5A);
        wait_acc(0, ok);
        cv[0] = 1'b0;
        check("fw_acc", ok, 1);
        wait_rsp(0, ok, d1);
        check("fw_lat", d1 - (hs_cyc[0] + 1), 72);
        repeat (2) @(posedge clk);
        #1;
        check("fw_rd", cp_rd[0], 8'h5A);

        // HALF_PERIOD=1: read TD C3
        td_val = 8'hC3;
        issue(1, 1'b0, 1'b0, 8'h00);
        wait_acc(1, ok);
        cv[1] = 1'b0;
        check("h1_acc", ok, 1);
        wait_rsp(1, ok, d1);
        check("h1_rsp", ok, 1);
        check("h1_lat", d1 - (hs_cyc[1] + 1), 18);
        check("h1_data", o_vec[1][7:0], 8'hC3);
        repeat (4) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
